// File: rtl/disp_pkg.sv
// Shared display-path types and default bus widths for the drawing engines.
package disp_pkg;

   localparam int unsigned DISP_AN = 24;
   localparam int unsigned DISP_DN = 16;

   typedef enum logic {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } flush_state_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// Register-array FIFO storage: one write port, head read straight from the flops.
module sync_fifo_mem #(
   parameter int unsigned W  = 40,
   parameter int unsigned AW = 4
) (
   input  logic          clkSYS,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [W-1:0]  wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [W-1:0]  rd_data
);

   localparam int unsigned DEPTH = 1 << AW;

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clkSYS) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/disp_wr_buffer.sv
// Posted-write FIFO between the drawing sequencer and the system memory arbiter,
// with a flush handshake that reports when every posted write has been consumed.
module disp_wr_buffer
   import disp_pkg::*;
#(
   parameter int unsigned AN         = DISP_AN,
   parameter int unsigned DN         = DISP_DN,
   parameter int unsigned DEPTH_LOG2 = 4
) (
   input  logic                  clkSYS,
   input  logic                  reset,
   input  logic [AN-1:0]         up_addr,
   input  logic [DN-1:0]         up_data,
   input  logic                  up_req,
   output logic                  up_ack,
   output logic [AN-1:0]         dn_addr,
   output logic [DN-1:0]         dn_data,
   output logic                  dn_req,
   input  logic                  dn_ack,
   input  logic                  flush,
   output logic                  flush_done,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   level,
   output logic [DEPTH_LOG2:0]   hwm
);

   localparam int unsigned PW = DEPTH_LOG2 + 1;
   localparam int unsigned EW = AN + DN;

   flush_state_t   state;
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;
   logic [PW-1:0]  level_next;
   logic           full;
   logic           push;
   logic           pop;
   logic [EW-1:0]  head;

   // Extra wrap bit on each pointer distinguishes full from empty.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                  (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
   assign level = wr_ptr - rd_ptr;

   assign up_ack = up_req & ~full & (state != DRAIN) & ~reset;
   assign push   = up_ack;
   assign pop    = ~empty & dn_ack;
   assign dn_req = ~empty;

   assign level_next = level + PW'(push) - PW'(pop);

   sync_fifo_mem #(
      .W  (EW),
      .AW (DEPTH_LOG2)
   ) u_mem (
      .clkSYS  (clkSYS),
      .wr_en   (push),
      .wr_addr (wr_ptr[DEPTH_LOG2-1:0]),
      .wr_data ({up_addr, up_data}),
      .rd_addr (rd_ptr[DEPTH_LOG2-1:0]),
      .rd_data (head)
   );

   assign {dn_addr, dn_data} = head;

   always_ff @(posedge clkSYS) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
      end
   end

   // High-water mark only ever grows until reset.
   always_ff @(posedge clkSYS) begin
      if (reset) begin
         hwm <= '0;
      end else if (level_next > hwm) begin
         hwm <= level_next;
      end
   end

   // Flush: block new pushes until the FIFO has drained, then pulse flush_done.
   always_ff @(posedge clkSYS) begin
      if (reset) begin
         state      <= IDLE;
         flush_done <= 1'b0;
      end else begin
         flush_done <= 1'b0;
         case (state)
            IDLE: begin
               if (flush) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (empty) begin
                  state      <= IDLE;
                  flush_done <= 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_disp_wr_buffer.sv
// Bench for disp_wr_buffer: directed vector table, directed corner sequences and
// random traffic checked against a queue-based reference model.
module tb_disp_wr_buffer;

   localparam int DEPTH = 16;

   logic        clkSYS;
   logic        reset;
   logic [23:0] up_addr;
   logic [15:0] up_data;
   logic        up_req;
   logic        up_ack;
   logic [23:0] dn_addr;
   logic [15:0] dn_data;
   logic        dn_req;
   logic        dn_ack;
   logic        flush;
   logic        flush_done;
   logic        empty;
   logic [4:0]  level;
   logic [4:0]  hwm;

   disp_wr_buffer #(
      .AN         (24),
      .DN         (16),
      .DEPTH_LOG2 (4)
   ) dut (
      .clkSYS     (clkSYS),
      .reset      (reset),
      .up_addr    (up_addr),
      .up_data    (up_data),
      .up_req     (up_req),
      .up_ack     (up_ack),
      .dn_addr    (dn_addr),
      .dn_data    (dn_data),
      .dn_req     (dn_req),
      .dn_ack     (dn_ack),
      .flush      (flush),
      .flush_done (flush_done),
      .empty      (empty),
      .level      (level),
      .hwm        (hwm)
   );

   initial clkSYS = 1'b0;
   always #5 clkSYS = ~clkSYS;

   typedef struct packed {
      logic [23:0] a;
      logic [15:0] d;
   } ent_t;

   typedef struct {
      logic        rst;
      logic        req;
      logic [23:0] a;
      logic [15:0] d;
      logic        ack;
      logic        fl;
      logic        e_ack;
      logic        e_dnreq;
      logic [4:0]  e_lvl;
      logic [4:0]  e_hwm;
      logic        e_fd;
      logic [23:0] e_addr;
      logic [15:0] e_data;
   } vec_t;

   int          n_vec;
   int          n_err;
   ent_t        m_q[$];
   bit          m_drain;
   bit          m_fd;
   int          m_hwm;
   bit          m_pushed;
   int          fd_seen;
   int          dut_acc;
   bit          log_en;
   logic [23:0] push_log[$];
   logic [23:0] pop_log[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_q.delete();
      m_drain = 1'b0;
      m_fd    = 1'b0;
      m_hwm   = 0;
   endtask

   // One clock cycle: drive at negedge, compare mid-low-phase, advance model at posedge.
   task automatic step(input logic rst, input logic req, input logic [23:0] a,
                       input logic [15:0] d, input logic ack, input logic fl);
      int   pre;
      logic e_ack;
      logic nfd;
      reset   = rst;
      up_req  = req;
      up_addr = a;
      up_data = d;
      dn_ack  = ack;
      flush   = fl;
      #1;
      pre   = m_q.size();
      e_ack = !rst && req && (pre < DEPTH) && !m_drain;
      chk("up_ack",     32'(up_ack),     32'(e_ack));
      chk("dn_req",     32'(dn_req),     32'(pre > 0));
      chk("empty",      32'(empty),      32'(pre == 0));
      chk("level",      32'(level),      32'(pre));
      chk("hwm",        32'(hwm),        32'(m_hwm));
      chk("flush_done", 32'(flush_done), 32'(m_fd));
      if (pre > 0) begin
         chk("dn_addr", 32'(dn_addr), 32'(m_q[0].a));
         chk("dn_data", 32'(dn_data), 32'(m_q[0].d));
      end
      if (flush_done) fd_seen++;
      if (up_ack) dut_acc++;
      if (log_en && dn_req && ack) pop_log.push_back(dn_addr);
      @(posedge clkSYS);
      m_pushed = e_ack;
      if (rst) begin
         model_clear();
      end else begin
         nfd = m_drain && (pre == 0);
         if (nfd) m_drain = 1'b0;
         else if (!m_drain && fl) m_drain = 1'b1;
         if (ack && pre > 0) void'(m_q.pop_front());
         if (e_ack) begin
            m_q.push_back('{a, d});
            if (log_en) push_log.push_back(a);
         end
         m_fd = nfd;
         if (m_q.size() > m_hwm) m_hwm = m_q.size();
      end
      @(negedge clkSYS);
   endtask

   task automatic idle(input logic ack);
      step(1'b0, 1'b0, 24'h0, 16'h0, ack, 1'b0);
   endtask

   task automatic raw_reset();
      reset   = 1'b1;
      up_req  = 1'b0;
      up_addr = '0;
      up_data = '0;
      dn_ack  = 1'b0;
      flush   = 1'b0;
      @(posedge clkSYS);
      @(posedge clkSYS);
      @(negedge clkSYS);
      reset = 1'b0;
      model_clear();
   endtask

   vec_t tbl[14];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
      $fatal(1);
   end

   initial begin
      n_vec   = 0;
      n_err   = 0;
      fd_seen = 0;
      dut_acc = 0;
      log_en  = 1'b0;
      model_clear();

      // rst req addr data ack flush | up_ack dn_req level hwm flush_done head_addr head_data
      tbl[0]  = '{1'b1, 1'b1, 24'h000123, 16'hF800, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 24'h0, 16'h0};
      tbl[1]  = '{1'b0, 1'b1, 24'h000123, 16'hF800, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 24'h0, 16'h0};
      tbl[2]  = '{1'b0, 1'b0, 24'h000000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 5'd1, 1'b0, 24'h000123, 16'hF800};
      tbl[3]  = '{1'b0, 1'b0, 24'h000000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 1'b0, 24'h0, 16'h0};
      tbl[4]  = '{1'b0, 1'b0, 24'h000000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd1, 1'b0, 24'h0, 16'h0};
      tbl[5]  = '{1'b0, 1'b1, 24'h000AAA, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 1'b0, 24'h0, 16'h0};
      tbl[6]  = '{1'b0, 1'b1, 24'h000456, 16'h07E0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd1, 1'b1, 24'h0, 16'h0};
      tbl[7]  = '{1'b0, 1'b0, 24'h000000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 5'd1, 1'b0, 24'h000456, 16'h07E0};
      tbl[8]  = '{1'b0, 1'b0, 24'h000000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 5'd1, 5'd1, 1'b0, 24'h000456, 16'h07E0};
      tbl[9]  = '{1'b0, 1'b1, 24'h000BBB, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 5'd1, 1'b0, 24'h000456, 16'h07E0};
      tbl[10] = '{1'b0, 1'b0, 24'h000000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 5'd1, 1'b0, 24'h000456, 16'h07E0};
      tbl[11] = '{1'b0, 1'b0, 24'h000000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 1'b0, 24'h0, 16'h0};
      tbl[12] = '{1'b0, 1'b0, 24'h000000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 1'b1, 24'h0, 16'h0};
      tbl[13] = '{1'b0, 1'b0, 24'h000000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 1'b0, 24'h0, 16'h0};

      @(negedge clkSYS);
      raw_reset();

      // Directed vector table: single write, empty flush, flush with one entry.
      for (int i = 0; i < 14; i++) begin
         reset   = tbl[i].rst;
         up_req  = tbl[i].req;
         up_addr = tbl[i].a;
         up_data = tbl[i].d;
         dn_ack  = tbl[i].ack;
         flush   = tbl[i].fl;
         #1;
         chk($sformatf("t%0d_up_ack", i),     32'(up_ack),     32'(tbl[i].e_ack));
         chk($sformatf("t%0d_dn_req", i),     32'(dn_req),     32'(tbl[i].e_dnreq));
         chk($sformatf("t%0d_empty", i),      32'(empty),      32'(tbl[i].e_lvl == 5'd0));
         chk($sformatf("t%0d_level", i),      32'(level),      32'(tbl[i].e_lvl));
         chk($sformatf("t%0d_hwm", i),        32'(hwm),        32'(tbl[i].e_hwm));
         chk($sformatf("t%0d_flush_done", i), 32'(flush_done), 32'(tbl[i].e_fd));
         if (tbl[i].e_dnreq) begin
            chk($sformatf("t%0d_dn_addr", i), 32'(dn_addr), 32'(tbl[i].e_addr));
            chk($sformatf("t%0d_dn_data", i), 32'(dn_data), 32'(tbl[i].e_data));
         end
         @(posedge clkSYS);
         @(negedge clkSYS);
      end

      // Fill: 20 requests with the sink stalled, exactly 16 accepted.
      raw_reset();
      dut_acc = 0;
      for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 24'(32'h200 + i), 16'(i), 1'b0, 1'b0);
      chk("fill_accepts", 32'(dut_acc), 32'd16);
      chk("fill_level",   32'(level),   32'd16);
      chk("fill_hwm",     32'(hwm),     32'd16);
      for (int i = 0; i < 16; i++) idle(1'b1);
      chk("fill_drained", 32'(empty), 32'd1);

      // Full with a simultaneous pop: push still blocked, next cycle accepted.
      for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 24'(32'h300 + i), 16'(i), 1'b0, 1'b0);
      step(1'b0, 1'b1, 24'h3AA, 16'h3AA, 1'b1, 1'b0);
      chk("full_pop_level", 32'(level), 32'd15);
      reset = 1'b0; up_req = 1'b1; dn_ack = 1'b0; flush = 1'b0;
      #1;
      chk("full_pop_next_ack", 32'(up_ack), 32'd1);
      step(1'b0, 1'b1, 24'h3BB, 16'h3BB, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) idle(1'b1);

      // Flush with 5 queued entries and a stalled sink.
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 24'(32'h400 + i), 16'(i), 1'b0, 1'b0);
      fd_seen = 0;
      step(1'b0, 1'b0, 24'h0, 16'h0, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 24'h4FF, 16'h4FF, 1'b0, 1'b0);
      for (int k = 0; k < 20 && fd_seen == 0; k++) idle(1'b1);
      chk("flush_done_seen", 32'(fd_seen), 32'd1);
      for (int i = 0; i < 3; i++) idle(1'b1);
      chk("flush_single_pulse", 32'(fd_seen), 32'd1);

      // Flush on an empty FIFO: flush_done two cycles after the flush cycle.
      step(1'b0, 1'b0, 24'h0, 16'h0, 1'b0, 1'b1);
      idle(1'b0);
      chk("empty_flush_done", 32'(flush_done), 32'd1);
      idle(1'b0);

      // Reset in the middle of a drain with 7 entries.
      for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 24'(32'h500 + i), 16'(i), 1'b0, 1'b0);
      step(1'b0, 1'b0, 24'h0, 16'h0, 1'b0, 1'b1);
      idle(1'b0);
      idle(1'b0);
      step(1'b1, 1'b1, 24'h5FF, 16'h5FF, 1'b0, 1'b0);
      chk("rst_empty",      32'(empty),      32'd1);
      chk("rst_level",      32'(level),      32'd0);
      chk("rst_hwm",        32'(hwm),        32'd0);
      chk("rst_dn_req",     32'(dn_req),     32'd0);
      chk("rst_flush_done", 32'(flush_done), 32'd0);
      for (int i = 0; i < 4; i++) idle(1'b0);

      // Wrap: 40 writes with the sink acknowledging every other cycle.
      push_log.delete();
      pop_log.delete();
      log_en = 1'b1;
      begin
         int n;
         n = 0;
         for (int c = 0; c < 300 && n < 40; c++) begin
            step(1'b0, 1'b1, 24'(32'h100 + n), 16'(n), 1'((c % 2) == 0), 1'b0);
            if (m_pushed) n++;
         end
      end
      for (int i = 0; i < 40 && m_q.size() > 0; i++) idle(1'b1);
      log_en = 1'b0;
      chk("wrap_pushes", 32'(push_log.size()), 32'd40);
      chk("wrap_pops",   32'(pop_log.size()),  32'd40);
      for (int i = 0; i < 40 && i < pop_log.size(); i++) begin
         chk($sformatf("wrap_order_%0d", i), 32'(pop_log[i]), 32'(24'(32'h100 + i)));
      end

      // Random traffic against the reference model.
      for (int i = 0; i < 1500; i++) begin
         step(1'($urandom_range(0, 299) == 0),
              1'($urandom_range(0, 3) != 0),
              24'($urandom),
              16'($urandom),
              1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 39) == 0));
      end
      for (int i = 0; i < 20; i++) idle(1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/disp_wr_buffer.md
Name: disp_wr_buffer

Overview:
- Posted-write FIFO between the display drawing sequencer (background/test/samples/FFT writers, muxed by the priority arbiter) and the system memory arbiter port.
- Decouples drawing engines from memory latency: writes are acknowledged upstream as soon as they are buffered, then replayed downstream in order.
- Provides a flush handshake so the sequencer can hold off the buffer swap until every posted pixel write has landed in memory.

Parameters:
- AN, 24, address width in bits (same as the arbiter interface AN).
- DN, 16, data width in bits (same as the arbiter interface DN).
- DEPTH_LOG2, 4, log2 of FIFO depth; depth = 2**DEPTH_LOG2 entries, legal range 1..8.

Ports:
- clkSYS  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- up_addr  in  AN  write address from the drawing-side arbiter.
- up_data  in  DN  write data from the drawing-side arbiter.
- up_req  in  1  write request; address/data are valid while high.
- up_ack  out  1  write accepted this cycle (combinational).
- dn_addr  out  AN  head-of-FIFO address to the system arbiter.
- dn_data  out  DN  head-of-FIFO data to the system arbiter.
- dn_req  out  1  head entry valid.
- dn_ack  in  1  system arbiter consumed the head entry this cycle.
- flush  in  1  single-cycle pulse requesting drain.
- flush_done  out  1  single-cycle pulse: FIFO empty after a flush.
- empty  out  1  FIFO holds no entries.
- level  out  DEPTH_LOG2+1  current entry count, 0..depth.
- hwm  out  DEPTH_LOG2+1  high-water mark of level since reset.

Behaviour:
- Reset (reset=1 at an edge): pointers=0, level=0, hwm=0, state=IDLE. Outputs after reset: empty=1, dn_req=0, flush_done=0. up_ack is 0 while reset=1. Any in-flight contents are discarded, including mid-flush.
- Upstream handshake (valid/ready): up_ack = up_req & ~full & (state != DRAIN) & ~reset. A push occurs on every edge where up_ack=1; the master advances its address/data on that same edge. No double-accept is possible.
- Downstream handshake: dn_req = ~empty; dn_addr/dn_data come directly from the head register (registered storage, no combinational path from up_* to dn_*). A pop occurs on an edge with dn_req & dn_ack. dn_ack while empty is ignored.
- Latency: an entry pushed into an empty FIFO appears on dn_req one cycle later. There is no bypass path.
- Ordering: strict FIFO. Addresses and data are passed unmodified, with no combining.
- Pointers are DEPTH_LOG2+1 bits with wrap bit: full = (MSBs differ & rest equal), empty = pointers equal. Wrap-around past depth is exercised naturally.
- Simultaneous push and pop:
  - Non-full, non-empty: level is unchanged.
  - When full: push is blocked (up_ack=0) even if a pop occurs that cycle.
  - When empty: only the push happens.
- hwm: updated to level_next whenever level_next > hwm. Cleared only by reset.
- Flush FSM (states IDLE, DRAIN):
  - IDLE + flush: go to DRAIN.
  - In DRAIN, pushes are blocked and pops continue.
  - DRAIN & empty: pulse flush_done for 1 cycle and return to IDLE.
  - flush while already empty: DRAIN for one cycle, so flush_done is asserted exactly 2 cycles after the flush pulse edge.
  - flush while in DRAIN is ignored; no second flush_done is generated.
- flush_done is registered; it is never high for 2 consecutive cycles.

Decomposition:
- disp_pkg holds:
  - flush_state_t enum {IDLE, DRAIN}.
  - Default AN/DN constants shared with the display drawing engines.
- Sub-module sync_fifo_mem: DEPTH×(AN+DN) register array with write port and registered head read, reusable elsewhere.
- disp_wr_buffer contains the pointers, level/hwm, handshake and flush FSM.

Test Plan:
- Single write: up_req with addr=0x000123, data=0xF800 for 1 cycle, dn_ack held 1 → up_ack=1 on the same cycle; dn_req=1 next cycle with 0x000123/0xF800; then empty=1.
- Fill with dn_ack=0, DEPTH_LOG2=4, 20 consecutive requests → exactly 16 accepted, up_ack=0 from request 17, level=16, hwm=16. Release dn_ack → 16 entries drain in push order.
- Wrap: 40 writes with dn_ack toggling 1/0 every cycle → all 40 addresses emerge in order, no loss or duplication; level never exceeds depth.
- Full plus simultaneous pop: FIFO full, dn_ack=1 and up_req=1 in the same cycle → level becomes 15, up_ack=0; up_ack=1 the following cycle.
- Flush: 5 entries queued, pulse flush, dn_ack stalled 10 cycles then held 1 → up_ack=0 throughout DRAIN; flush_done pulses once, 1 cycle after the last pop. A flush on an empty FIFO gives flush_done 2 cycles later.
- Reset mid-DRAIN with 7 entries → the next cycle shows empty=1, level=0, hwm=0, dn_req=0, no flush_done.
